// File: rtl/rmc_req_arbiter.sv
// Shares the RMC request FIFO among NUM_REQ requesters and routes read-return words back to their issuers.
// Build option: define RMC_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rmc_req_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_type,
    input  logic [NUM_REQ*DATA_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    input  logic [NUM_REQ-1:0]        wdata_valid,
    output logic [NUM_REQ-1:0]        wdata_ready,
    output logic [DATA_W-1:0]         req_fifo_data_in,
    output logic                      req_fifo_enq,
    input  logic                      req_fifo_wrfull,
    input  logic [DATA_W-1:0]         read_fifo_data_out,
    input  logic                      read_fifo_rdempty,
    output logic                      read_fifo_deq,
    output logic [DATA_W-1:0]         rd_data,
    output logic [NUM_REQ-1:0]        rd_valid
);

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR0, S_HDR1, S_WDATA} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     gnt_q, gnt_d;
    logic                type_q, type_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    wcnt_q, wcnt_d;

    logic [ID_W-1:0]     tag_id_q  [TAG_DEPTH];
    logic [ID_W-1:0]     tag_id_d  [TAG_DEPTH];
    logic [LEN_W-1:0]    tag_len_q [TAG_DEPTH];
    logic [LEN_W-1:0]    tag_len_d [TAG_DEPTH];
    logic [PTR_W-1:0]    tag_wr_q, tag_wr_d;
    logic [PTR_W-1:0]    tag_rd_q, tag_rd_d;
    logic [CNT_W-1:0]    tag_cnt_q, tag_cnt_d;
    logic [LEN_W-1:0]    ret_cnt_q, ret_cnt_d;

    logic                tag_full, tag_empty, tag_push, tag_pop;
    logic [LEN_W-1:0]    ret_eff;
    logic [NUM_REQ-1:0]  elig;
    logic                gnt_found;
    logic [ID_W-1:0]     gnt_idx;
    logic [LEN_W-1:0]    in_len, in_len_clamped;
    logic                deq;

    assign tag_full  = (tag_cnt_q == CNT_W'(TAG_DEPTH));
    assign tag_empty = (tag_cnt_q == '0);
    assign elig      = req_valid & (req_type | {NUM_REQ{~tag_full}});

`ifdef RMC_ARB_FIXED_PRIO_EN
    // Lowest eligible index wins
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            idx = ID_W'(k);
            if (elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end
`else
    logic [ID_W-1:0] rr_q, rr_d;

    // First eligible index after rr_q; scan farthest first so the nearest overrides
    always_comb begin
        logic [ID_W-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_q) + NUM_REQ - k) % NUM_REQ);
            if (elig[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (!rst && state_q == S_IDLE && gnt_found) begin
            rr_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign in_len         = req_len[gnt_idx*LEN_W +: LEN_W];
    assign in_len_clamped = (32'(in_len) > MAX_WORDS) ? LEN_W'(MAX_WORDS) : in_len;

    // Request serializer: grant, two header words, then write data
    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        type_d           = type_q;
        addr_d           = addr_q;
        len_d            = len_q;
        wcnt_d           = wcnt_q;
        req_ready        = '0;
        wdata_ready      = '0;
        req_fifo_enq     = 1'b0;
        req_fifo_data_in = '0;
        tag_push         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    gnt_d  = gnt_idx;
                    type_d = req_type[gnt_idx];
                    addr_d = req_addr[gnt_idx*DATA_W +: DATA_W];
                    len_d  = in_len_clamped;
                    if (in_len != '0) begin
                        state_d = S_HDR0;
                    end
                end
            end
            S_HDR0: begin
                req_fifo_enq            = !req_fifo_wrfull;
                req_fifo_data_in[0]     = type_q;
                req_fifo_data_in[LEN_W:1] = len_q;
                if (req_fifo_enq) begin
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                req_fifo_enq     = !req_fifo_wrfull;
                req_fifo_data_in = addr_q;
                if (req_fifo_enq) begin
                    if (type_q) begin
                        state_d = S_WDATA;
                        wcnt_d  = len_q;
                    end else begin
                        tag_push = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_WDATA: begin
                req_fifo_enq         = wdata_valid[gnt_q] & !req_fifo_wrfull;
                wdata_ready[gnt_q]   = req_fifo_enq;
                req_fifo_data_in     = wdata[gnt_q*DATA_W +: DATA_W];
                if (req_fifo_enq) begin
                    wcnt_d = wcnt_q - LEN_W'(1);
                    if (wcnt_q == LEN_W'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            req_ready        = '0;
            wdata_ready      = '0;
            req_fifo_enq     = 1'b0;
            req_fifo_data_in = '0;
            tag_push         = 1'b0;
        end
    end

    // Read return: head tag steers dequeued words to their requester
    assign deq     = !rst && !read_fifo_rdempty && !tag_empty;
    assign ret_eff = (ret_cnt_q == '0) ? tag_len_q[tag_rd_q] : ret_cnt_q;
    assign tag_pop = deq && (ret_eff == LEN_W'(1));

    always_comb begin
        read_fifo_deq = deq;
        rd_data       = deq ? read_fifo_data_out : '0;
        rd_valid      = '0;
        if (deq) begin
            rd_valid[tag_id_q[tag_rd_q]] = 1'b1;
        end
    end

    always_comb begin
        tag_id_d  = tag_id_q;
        tag_len_d = tag_len_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        tag_cnt_d = tag_cnt_q;
        ret_cnt_d = deq ? (ret_eff - LEN_W'(1)) : ret_cnt_q;
        if (tag_push) begin
            tag_id_d[tag_wr_q]  = gnt_q;
            tag_len_d[tag_wr_q] = len_q;
            tag_wr_d = (tag_wr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : tag_wr_q + PTR_W'(1);
        end
        if (tag_pop) begin
            tag_rd_d = (tag_rd_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : tag_rd_q + PTR_W'(1);
        end
        case ({tag_push, tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + CNT_W'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CNT_W'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            type_q    <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wcnt_q    <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
            ret_cnt_q <= '0;
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                tag_id_q[i]  <= '0;
                tag_len_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            tag_cnt_q <= tag_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            tag_id_q  <= tag_id_d;
            tag_len_q <= tag_len_d;
        end
    end

endmodule

// File: doc/rmc_req_arbiter.md
Name: rmc_req_arbiter

Overview:
- Shares the single RMC request FIFO between NUM_REQ requesters.
- Round-robin selects one request and serializes it into the FIFO word stream: header word 0 = {num_words, req_type}, header word 1 = address, then num_words data words for WRITE only.
- Tracks outstanding READs in issue order and steers words dequeued from the read-return FIFO back to the requester that issued them.
- Sits between the requester ports and the req_fifo write side / read_fifo read side of cpu_rmc.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, FIFO word width (CPU_DATA_WIDTH).
- MAX_WORDS, 8, maximum words per request.
- LEN_W, 4, width of req_len; must hold MAX_WORDS.
- TAG_DEPTH, 4, outstanding-READ tracking depth (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  request descriptor valid, one bit per requester
- req_ready  out  NUM_REQ  descriptor accepted this cycle
- req_type  in  NUM_REQ  0 = READ, 1 = WRITE
- req_addr  in  NUM_REQ*DATA_W  start address; requester i uses slice [i*DATA_W +: DATA_W]
- req_len  in  NUM_REQ*LEN_W  number of words
- wdata  in  NUM_REQ*DATA_W  write data stream
- wdata_valid  in  NUM_REQ  write data valid
- wdata_ready  out  NUM_REQ  write data consumed
- req_fifo_data_in  out  DATA_W  word to request FIFO
- req_fifo_enq  out  1  enqueue strobe
- req_fifo_wrfull  in  1  request FIFO full
- read_fifo_data_out  in  DATA_W  read-return head word (show-ahead)
- read_fifo_rdempty  in  1  read-return FIFO empty
- read_fifo_deq  out  1  dequeue strobe
- rd_data  out  DATA_W  returned read word, shared by all requesters
- rd_valid  out  NUM_REQ  one-hot: rd_data belongs to requester i

Behaviour:
- Reset: FSM to IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first. Tag queue empty, return counter = 0. All outputs 0.
- FSM states: IDLE -> HDR0 -> HDR1 -> (WDATA | IDLE).
- IDLE:
  - Eligible requesters: req_valid=1 AND (req_type=WRITE OR tag queue not full).
  - Grant the first eligible index after the rr pointer, cyclically.
  - In the grant cycle: req_ready[g]=1; latch g, type, addr, len; update rr pointer to g; go to HDR0.
  - req_len=0: accept and drop it; nothing is emitted and the FSM stays in IDLE.
  - req_len>MAX_WORDS: latch MAX_WORDS instead.
- HDR0: drive data = {len zero-extended to DATA_W-1 bits, type}.
- HDR1: drive data = addr. On a READ, push {g, len} to the tag queue in the same cycle the enq succeeds.
- Enqueue rule for HDR0/HDR1: req_fifo_enq = !req_fifo_wrfull. The state advances only on a cycle where enq=1.
- After HDR1: READ -> IDLE; WRITE -> WDATA with word counter = len.
- WDATA:
  - req_fifo_enq = wdata_valid[g] & !req_fifo_wrfull; wdata_ready[g] = req_fifo_enq; data = wdata[g].
  - Counter decrements per enq; last word -> IDLE.
- req_fifo_enq is never 1 while req_fifo_wrfull=1. Data words of one request are never interleaved with another request.
- Minimum request length on the FIFO: READ = 2 cycles, WRITE = 2+len cycles. Grant costs one cycle (IDLE). No back-to-back overlap of grant and emission.
- Read return:
  - read_fifo_deq = !read_fifo_rdempty & (tag queue not empty).
  - On deq: rd_data = read_fifo_data_out and rd_valid[tag.id]=1 in the same cycle (combinational).
  - Return counter loads tag.len on the first word and decrements per deq; the tag pops on the last word.
  - A tag push and pop in the same cycle are both honoured; occupancy is unchanged.
- Requesters must accept rd_valid unconditionally; there is no backpressure on the return path.
- A read_fifo word arriving while the tag queue is empty is not dequeued.
- rst mid-request returns everything to the reset state. A partially written request is abandoned; the FIFO side is reset together with this block.

Optional Feature:
- Macro: RMC_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest eligible index wins; the rr pointer is removed.
- Undefined (default): round-robin as in Behaviour.
- Everything else is identical in both builds.

Test Plan:
- Req0 WRITE addr=0x10 len=3 data A,B,C, FIFO never full -> enq stream {3,1}=0x7, 0x10, A, B, C on 5 consecutive cycles after the grant cycle.
- Req1 READ addr=0x20 len=2; read_fifo later supplies X,Y -> enq 0x4, 0x20; rd_valid=4'b0010 with rd_data X then Y.
- Req0..3 all valid WRITE len=1 simultaneously, round-robin build -> grant order 0,1,2,3. Holding all valid afterwards gives 0 again. With RMC_ARB_FIXED_PRIO_EN and req0 always valid -> only 0 granted.
- Hold req_fifo_wrfull=1 for 5 cycles during WDATA of a len=4 write -> req_fifo_enq=0 and wdata_ready=0 throughout; the stream resumes intact with no dropped or duplicated word.
- 5 READs of len=1 from req2 with TAG_DEPTH=4 and read_fifo empty -> 4 accepted, 5th req_ready stays 0 until the first return word is dequeued.
- Assert rst during WDATA word 2 of 4 -> next cycle all outputs 0, FSM idle, rr pointer back to NUM_REQ-1, tag queue empty.
